// File: rtl/immx_pkg.sv
// Shared definitions for the immediate-extension stage and its core.
package immx_pkg;

   // Width of the extension mode select
   localparam int MODE_W = 2;

   // Extension modes
   localparam logic [MODE_W-1:0] IMMX_SIGN   = 2'b00;
   localparam logic [MODE_W-1:0] IMMX_ZERO   = 2'b01;
   localparam logic [MODE_W-1:0] IMMX_UPPER  = 2'b10;
   localparam logic [MODE_W-1:0] IMMX_BRANCH = 2'b11;

   // Width of the optional stall counter
   localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/immx_extend_core.sv
// Combinational immediate widener: sign, zero, upper-placement and
// branch-offset (sign-extend then x4, top two bits dropped).
module immx_extend_core
   import immx_pkg::*;
#(
   parameter int IN_W  = 17,
   parameter int OUT_W = 32
) (
   input  logic [IN_W-1:0]   imm,
   input  logic [MODE_W-1:0] mode,
   output logic [OUT_W-1:0]  ext
);

   localparam int PAD_W = OUT_W - IN_W;

   logic [OUT_W-1:0] sext;

   assign sext = {{PAD_W{imm[IN_W-1]}}, imm};

   // Select the widened form for the requested mode
   always_comb begin
      ext = sext;
      case (mode)
         IMMX_SIGN:   ext = sext;
         IMMX_ZERO:   ext = {{PAD_W{1'b0}}, imm};
         IMMX_UPPER:  ext = {imm, {PAD_W{1'b0}}};
         IMMX_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
         default:     ext = sext;
      endcase
   end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered immediate-extension stage with valid/ready handshake and a
// 2-entry (main + skid) buffer. in_ready depends on registered state only.
// Optional feature macro: IMMX_STALL_CNT_EN adds a saturating stall counter.
module imm_extend_stage
   import immx_pkg::*;
#(
   parameter int IN_W   = 17,
   parameter int OUT_W  = 32,
   parameter int MODE_W = immx_pkg::MODE_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in_imm,
   input  logic [MODE_W-1:0] in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_neg
`ifdef IMMX_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   if (IN_W >= OUT_W || IN_W < 2) begin : g_bad_width
      $error("imm_extend_stage: IN_W must satisfy 2 <= IN_W < OUT_W");
   end
   if (MODE_W != immx_pkg::MODE_W) begin : g_bad_mode_w
      $error("imm_extend_stage: MODE_W is fixed and must not be overridden");
   end

   logic [OUT_W-1:0] ext;
   logic             ext_neg;
   logic             accept;
   logic             main_free;

   logic             main_valid_q, main_valid_d;
   logic [OUT_W-1:0] main_data_q,  main_data_d;
   logic             main_neg_q,   main_neg_d;
   logic             skid_valid_q, skid_valid_d;
   logic [OUT_W-1:0] skid_data_q,  skid_data_d;
   logic             skid_neg_q,   skid_neg_d;

   immx_extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .imm  (in_imm),
      .mode (in_mode),
      .ext  (ext)
   );

   assign ext_neg   = in_imm[IN_W-1];
   assign in_ready  = !skid_valid_q && !reset;
   assign accept    = in_valid && in_ready;
   assign main_free = !main_valid_q || out_ready;

   assign out_valid = main_valid_q;
   assign out_data  = main_data_q;
   assign out_neg   = main_neg_q;

   // Next-state for the main/skid buffer pair (FIFO order, skid drains first)
   always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_neg_d   = main_neg_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_neg_d   = skid_neg_q;
      if (main_free) begin
         if (skid_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = skid_data_q;
            main_neg_d   = skid_neg_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = ext;
            main_neg_d   = ext_neg;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = ext;
         skid_neg_d   = ext_neg;
      end
   end

   // Buffer registers; reset clears valids and the visible output
   always_ff @(posedge clock) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_neg_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_neg_q   <= 1'b0;
      end else begin
         main_valid_q <= main_valid_d;
         main_data_q  <= main_data_d;
         main_neg_q   <= main_neg_d;
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_neg_q   <= skid_neg_d;
      end
   end

`ifdef IMMX_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Count cycles where output is held by the consumer, saturating
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid_q && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   // Stall counter register, cleared only by reset
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule
